operand_issue: RTL

//  Decode/operand-fetch stage directly upstream of the ALU. Accepts one instruction
//  per cycle, decodes R-type (0x33) and OP-IMM (0x13), reads the 32x32 register file,
//  and presents registered A/B/funct3/funct7/rd to the ALU stage over valid/ready.

---
 rtl/operand_issue_if.sv | 33 +++
 rtl/operand_issue.sv | 123 ++++++++++++
 2 files changed

// File: rtl/operand_issue_if.sv
// Handshake and writeback bundle between the decode/operand-fetch stage, its
// instruction source, the ALU stage and the writeback path.
interface operand_issue_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_a;
  logic [XLEN-1:0] out_b;
  logic [2:0]      out_funct3;
  logic [6:0]      out_funct7;
  logic [4:0]      out_rd;
  logic            out_we;
  logic            wb_valid;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            illegal;

  modport slave (
    input  in_valid, in_instr, out_ready, wb_valid, wb_rd, wb_data,
    output in_ready, out_valid, out_a, out_b, out_funct3, out_funct7,
           out_rd, out_we, illegal
  );

  modport master (
    output in_valid, in_instr, out_ready, wb_valid, wb_rd, wb_data,
    input  in_ready, out_valid, out_a, out_b, out_funct3, out_funct7,
           out_rd, out_we, illegal
  );
endinterface

// File: rtl/operand_issue.sv
// Decode/operand-fetch stage ahead of the ALU: decodes R-type and OP-IMM, reads the
// register file with writeback bypass, and stalls on RAW hazards via a scoreboard.
module operand_issue #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  operand_issue_if.slave bus
);

  localparam logic [6:0] OPC_R   = 7'h33;
  localparam logic [6:0] OPC_IMM = 7'h13;

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [NREGS-1:0] pend_q, pend_d;

  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] out_a_q, out_b_q;
  logic [2:0]      out_funct3_q;
  logic [6:0]      out_funct7_q;
  logic [4:0]      out_rd_q;
  logic            out_we_q;
  logic            illegal_q;

  logic [6:0]      opcode;
  logic [4:0]      rs1, rs2, rd;
  logic            is_r, is_imm, legal;
  logic            wb_hit1, wb_hit2;
  logic [XLEN-1:0] rs1_val, rs2_val, imm_val;
  logic            hazard, in_ready, accept, issue;

  assign opcode = bus.in_instr[6:0];
  assign rd     = bus.in_instr[11:7];
  assign rs1    = bus.in_instr[19:15];
  assign rs2    = bus.in_instr[24:20];
  assign is_r   = (opcode == OPC_R);
  assign is_imm = (opcode == OPC_IMM);
  assign legal  = is_r | is_imm;

  assign imm_val = {{(XLEN-12){bus.in_instr[31]}}, bus.in_instr[31:20]};

  // A value being written back this cycle is forwarded and also resolves the hazard.
  assign wb_hit1 = bus.wb_valid && (bus.wb_rd == rs1) && (rs1 != 5'd0);
  assign wb_hit2 = bus.wb_valid && (bus.wb_rd == rs2) && (rs2 != 5'd0);

  always_comb begin
    rs1_val = regs_q[rs1];
    if (rs1 == 5'd0)  rs1_val = '0;
    else if (wb_hit1) rs1_val = bus.wb_data;
  end

  always_comb begin
    rs2_val = regs_q[rs2];
    if (rs2 == 5'd0)  rs2_val = '0;
    else if (wb_hit2) rs2_val = bus.wb_data;
  end

  assign hazard   = bus.in_valid & legal &
                    ((pend_q[rs1] & ~wb_hit1) | (is_r & pend_q[rs2] & ~wb_hit2));
  assign in_ready = (~out_valid_q | bus.out_ready) & ~hazard;
  assign accept   = bus.in_valid & in_ready;
  assign issue    = accept & legal;

  always_comb begin
    out_valid_d = out_valid_q;
    if (issue)              out_valid_d = 1'b1;
    else if (bus.out_ready) out_valid_d = 1'b0;
  end

  // Set beats clear when the same register is retired and re-targeted together.
  always_comb begin
    pend_d = pend_q;
    if (bus.wb_valid)            pend_d[bus.wb_rd] = 1'b0;
    if (issue && rd != 5'd0)     pend_d[rd]        = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (bus.wb_valid && bus.wb_rd != 5'd0) begin
      regs_q[bus.wb_rd] <= bus.wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q       <= '0;
      out_valid_q  <= 1'b0;
      illegal_q    <= 1'b0;
      out_a_q      <= '0;
      out_b_q      <= '0;
      out_funct3_q <= '0;
      out_funct7_q <= '0;
      out_rd_q     <= '0;
      out_we_q     <= 1'b0;
    end else begin
      pend_q      <= pend_d;
      out_valid_q <= out_valid_d;
      illegal_q   <= accept & ~legal;
      if (issue) begin
        out_a_q      <= rs1_val;
        out_b_q      <= is_r ? rs2_val : imm_val;
        out_funct3_q <= bus.in_instr[14:12];
        out_funct7_q <= is_r ? bus.in_instr[31:25] : 7'h00;
        out_rd_q     <= rd;
        out_we_q     <= (rd != 5'd0);
      end
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_a      = out_a_q;
  assign bus.out_b      = out_b_q;
  assign bus.out_funct3 = out_funct3_q;
  assign bus.out_funct7 = out_funct7_q;
  assign bus.out_rd     = out_rd_q;
  assign bus.out_we     = out_we_q;
  assign bus.illegal    = illegal_q;

endmodule
